// File: rtl/frame_diff_bbox.sv
// Frame-difference motion mask and per-frame bounding box of moving pixels.
// Optional FRAME_DIFF_OVERLAY_EN adds post_y, the delayed luma with the latched box drawn in white.
module frame_diff_bbox #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_de,
    input  logic [7:0]  cur_y,
    input  logic [7:0]  prev_y,
    input  logic [7:0]  threshold,
    output logic        post_frame_vsync,
    output logic        post_frame_hsync,
    output logic        post_frame_de,
    output logic        bin_pix,
    output logic [10:0] box_left,
    output logic [10:0] box_right,
    output logic [9:0]  box_top,
    output logic [9:0]  box_bottom,
    output logic        box_valid,
    output logic        box_update
`ifdef FRAME_DIFF_OVERLAY_EN
    ,
    output logic [7:0]  post_y
`endif
);

    localparam logic [10:0] X_MAX   = 11'(IMG_W - 1);
    localparam logic [9:0]  Y_MAX   = 10'(IMG_H - 1);
    localparam logic [19:0] CNT_MIN = 20'(MIN_PIXELS);

    // ---------------- input-stage coordinates ----------------
    logic        vs_d, de_d;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_d <= pre_frame_vsync;
            de_d <= pre_frame_de;
            if (pre_frame_de)
                x_cnt <= (x_cnt == X_MAX) ? x_cnt : x_cnt + 11'd1;
            else if (de_d)
                x_cnt <= '0;
            // vsync rise wins over a coincident end-of-line
            if (pre_frame_vsync && !vs_d)
                y_cnt <= '0;
            else if (de_d && !pre_frame_de)
                y_cnt <= (y_cnt == Y_MAX) ? y_cnt : y_cnt + 10'd1;
        end
    end

    // ---------------- S1: absolute difference ----------------
    logic [8:0] diff_raw;
    logic [7:0] diff_abs;

    always_comb begin
        diff_raw = {1'b0, cur_y} - {1'b0, prev_y};
        diff_abs = diff_raw[8] ? (~diff_raw[7:0] + 8'd1) : diff_raw[7:0];
    end

    logic [1:0]  vs_pipe, hs_pipe, vld_pipe;
    logic        vs_s3;
    logic [7:0]  diff_s1;
    logic [10:0] x_s1, x_s2;
    logic [9:0]  y_s1, y_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_pipe  <= '0;
            hs_pipe  <= '0;
            vld_pipe <= '0;
            vs_s3    <= 1'b0;
            diff_s1  <= '0;
            x_s1     <= '0;
            y_s1     <= '0;
            x_s2     <= '0;
            y_s2     <= '0;
            bin_pix  <= 1'b0;
        end else begin
            vs_pipe  <= {vs_pipe[0], pre_frame_vsync};
            hs_pipe  <= {hs_pipe[0], pre_frame_hsync};
            vld_pipe <= {vld_pipe[0], pre_frame_de};
            vs_s3    <= vs_pipe[1];
            diff_s1  <= diff_abs;
            x_s1     <= x_cnt;
            y_s1     <= y_cnt;
            x_s2     <= x_s1;
            y_s2     <= y_s1;
            bin_pix  <= vld_pipe[0] && (diff_s1 > threshold);
        end
    end

    assign post_frame_vsync = vs_pipe[1];
    assign post_frame_hsync = hs_pipe[1];
    assign post_frame_de    = vld_pipe[1];

    // ---------------- S2: box accumulation ----------------
    logic        frame_close;
    logic [10:0] acc_l, acc_r;
    logic [9:0]  acc_t, acc_b;
    logic [19:0] acc_cnt;

    assign frame_close = vs_pipe[1] && !vs_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_l      <= X_MAX;
            acc_r      <= '0;
            acc_t      <= Y_MAX;
            acc_b      <= '0;
            acc_cnt    <= '0;
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            box_valid  <= 1'b0;
            box_update <= 1'b0;
        end else begin
            box_update <= frame_close;
            if (frame_close) begin
                // a moving pixel coinciding with the close is dropped on purpose
                if (acc_cnt >= CNT_MIN) begin
                    box_left   <= acc_l;
                    box_right  <= acc_r;
                    box_top    <= acc_t;
                    box_bottom <= acc_b;
                    box_valid  <= 1'b1;
                end else begin
                    box_left   <= '0;
                    box_right  <= '0;
                    box_top    <= '0;
                    box_bottom <= '0;
                    box_valid  <= 1'b0;
                end
                acc_l   <= X_MAX;
                acc_r   <= '0;
                acc_t   <= Y_MAX;
                acc_b   <= '0;
                acc_cnt <= '0;
            end else if (bin_pix) begin
                if (x_s2 < acc_l) acc_l <= x_s2;
                if (x_s2 > acc_r) acc_r <= x_s2;
                if (y_s2 < acc_t) acc_t <= y_s2;
                if (y_s2 > acc_b) acc_b <= y_s2;
                if (acc_cnt != '1) acc_cnt <= acc_cnt + 20'd1;
            end
        end
    end

`ifdef FRAME_DIFF_OVERLAY_EN
    // ---------------- overlay ----------------
    logic [7:0] y_s1_luma, y_s2_luma;
    logic       on_vert, on_horz;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_s1_luma <= '0;
            y_s2_luma <= '0;
        end else begin
            y_s1_luma <= cur_y;
            y_s2_luma <= y_s1_luma;
        end
    end

    always_comb begin
        on_vert = ((x_s2 == box_left) || (x_s2 == box_right)) &&
                  (y_s2 >= box_top) && (y_s2 <= box_bottom);
        on_horz = ((y_s2 == box_top) || (y_s2 == box_bottom)) &&
                  (x_s2 >= box_left) && (x_s2 <= box_right);
        post_y  = '0;
        if (post_frame_de)
            post_y = (box_valid && (on_vert || on_horz)) ? 8'd255 : y_s2_luma;
    end
`endif

endmodule

// File: tb/tb_frame_diff_bbox.sv
// Directed self-checking bench for frame_diff_bbox (default 640x480, MIN_PIXELS=16).
module tb_frame_diff_bbox;

    logic        clk = 1'b0;
    logic        rst;
    logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
    logic [7:0]  cur_y, prev_y, threshold;
    logic        post_frame_vsync, post_frame_hsync, post_frame_de, bin_pix;
    logic [10:0] box_left, box_right;
    logic [9:0]  box_top, box_bottom;
    logic        box_valid, box_update;
`ifdef FRAME_DIFF_OVERLAY_EN
    logic [7:0]  post_y;
`endif

    int tests = 0;
    int fails = 0;
    int binsum = 0;
    int misalign = 0;
    logic [7:0] cap_y [0:1023];

    always #5 clk = ~clk;

    frame_diff_bbox dut (
        .clk(clk), .rst(rst),
        .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
        .pre_frame_de(pre_frame_de), .cur_y(cur_y), .prev_y(prev_y),
        .threshold(threshold),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_de(post_frame_de), .bin_pix(bin_pix),
        .box_left(box_left), .box_right(box_right),
        .box_top(box_top), .box_bottom(box_bottom),
        .box_valid(box_valid), .box_update(box_update)
`ifdef FRAME_DIFF_OVERLAY_EN
        , .post_y(post_y)
`endif
    );

    always @(negedge clk) begin
        if (bin_pix) binsum++;
        if (bin_pix && !post_frame_de) misalign++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One line of len pixels; pixels ms..me carry c/p, the rest base/base.
    task automatic line(input int len, input int ms, input int me,
                        input logic [7:0] c, input logic [7:0] p, input logic [7:0] base);
        for (int i = 0; i < len + 2; i++) begin
            @(negedge clk);
`ifdef FRAME_DIFF_OVERLAY_EN
            if (i >= 2) cap_y[i-2] = post_y;
`endif
            if (i < len) begin
                pre_frame_de    = 1'b1;
                pre_frame_hsync = 1'b0;
                cur_y  = (i >= ms && i <= me) ? c : base;
                prev_y = (i >= ms && i <= me) ? p : base;
            end else begin
                pre_frame_de    = 1'b0;
                pre_frame_hsync = 1'b1;
                cur_y  = base;
                prev_y = base;
            end
        end
        @(negedge clk);
        pre_frame_hsync = 1'b0;
    endtask

    task automatic blank_lines(input int n);
        for (int i = 0; i < n; i++) line(1, 1, 0, 8'd0, 8'd0, 8'd100);
    endtask

    task automatic frame_close(input string tag, input logic ev, input int l, input int r,
                               input int t, input int b);
        int n;
        @(negedge clk);
        pre_frame_vsync = 1'b1;
        n = 0;
        while (!box_update && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_upd"}, box_update, 1);
        chk({tag, "_valid"}, box_valid, ev);
        chk({tag, "_left"}, box_left, l);
        chk({tag, "_right"}, box_right, r);
        chk({tag, "_top"}, box_top, t);
        chk({tag, "_bottom"}, box_bottom, b);
        @(negedge clk);
        chk({tag, "_upd_pulse"}, box_update, 0);
        pre_frame_vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pix_check(input string tag, input logic [7:0] c, input logic [7:0] p,
                             input logic exp);
        @(negedge clk);
        pre_frame_de = 1'b1; cur_y = c; prev_y = p;
        @(negedge clk);
        pre_frame_de = 1'b0; cur_y = 8'd100; prev_y = 8'd100;
        chk({tag, "_early"}, bin_pix, 0);
        @(negedge clk);
        chk(tag, bin_pix, exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pre_frame_vsync = 0; pre_frame_hsync = 0; pre_frame_de = 0;
        cur_y = 8'd100; prev_y = 8'd100; threshold = 8'd30;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {post_frame_vsync, post_frame_hsync, post_frame_de, bin_pix,
                            box_valid, box_update}, 0);
        chk("rst_box", {box_left, box_right, box_top, box_bottom}, 0);
        rst = 1'b0;

        // sync passthrough, 2-cycle delay
        @(negedge clk); pre_frame_hsync = 1'b1;
        @(negedge clk); pre_frame_hsync = 1'b0;
        chk("hs_delay1", post_frame_hsync, 0);
        @(negedge clk);
        chk("hs_delay2", post_frame_hsync, 1);
        repeat (2) @(negedge clk);

        frame_close("f0", 0, 0, 0, 0, 0);

        // 1: identical frames
        binsum = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) line(20, 0, 19, 8'd100, 8'd100, 8'd100);
            frame_close("ident", 0, 0, 0, 0, 0);
        end
        chk("ident_bins", binsum, 0);

        // 2: 10x10 block
        binsum = 0; misalign = 0;
        blank_lines(50);
        for (int k = 0; k < 10; k++) line(110, 100, 109, 8'd200, 8'd50, 8'd100);
        chk("block_bins", binsum, 100);
        chk("block_align", misalign, 0);
        frame_close("block", 1, 100, 109, 50, 59);

`ifdef FRAME_DIFF_OVERLAY_EN
        // 6: overlay of the latched box on a flat frame
        for (int k = 0; k < 60; k++) begin
            line(110, 1, 0, 8'd0, 8'd0, 8'd20);
            if (k == 50) begin
                chk("ov_99_50", cap_y[99], 20);
                chk("ov_105_50", cap_y[105], 255);
            end
            if (k == 55) begin
                chk("ov_100_55", cap_y[100], 255);
                chk("ov_105_55", cap_y[105], 20);
            end
            if (k == 59) chk("ov_109_59", cap_y[109], 255);
        end
        chk("ov_de_low", post_y, 0);
        frame_close("ov", 0, 0, 0, 0, 0);
`endif

        // 3: threshold boundaries
        threshold = 8'd30;
        pix_check("thr_eq", 8'd130, 8'd100, 0);
        pix_check("thr_gt", 8'd131, 8'd100, 1);
        pix_check("thr_neg", 8'd10, 8'd41, 1);
        threshold = 8'd0;
        pix_check("thr0_one", 8'd101, 8'd100, 1);
        pix_check("thr0_eq", 8'd77, 8'd77, 0);
        threshold = 8'd255;
        pix_check("thr255", 8'd0, 8'd255, 0);
        threshold = 8'd30;
        frame_close("thr", 0, 0, 0, 0, 0);

        // 4: MIN_PIXELS boundary
        line(15, 0, 14, 8'd200, 8'd50, 8'd100);
        frame_close("min15", 0, 0, 0, 0, 0);
        line(16, 0, 15, 8'd200, 8'd50, 8'd100);
        frame_close("min16", 1, 0, 15, 0, 0);

        // x saturation: pixels past IMG_W-1 reuse x=639
        line(645, 629, 644, 8'd200, 8'd50, 8'd100);
        frame_close("xsat", 1, 629, 639, 0, 0);

        // 5: reset mid-frame
        line(50, 0, 49, 8'd200, 8'd50, 8'd100);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_valid", box_valid, 0);
        chk("midrst_left", box_left, 0);
        blank_lines(200);
        line(320, 300, 319, 8'd200, 8'd50, 8'd100);
        frame_close("midrst", 1, 300, 319, 200, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
